// File: rtl/cordic_pkg.sv
// Shared angle types and constants for the CORDIC receive path.
package cordic_pkg;

   localparam int ANGLE_W    = 16;
   localparam int ANGLE_HALF = 180;
   localparam int ANGLE_FULL = 360;

   typedef logic signed [ANGLE_W-1:0] angle_t;

   typedef enum logic {
      PRIME,
      RUN
   } slicer_state_t;

endpackage

// File: rtl/phase_wrap.sv
// Wrapped phase difference cur - prev, result in (-180, 180] degrees.
module phase_wrap
   import cordic_pkg::*;
(
   input  angle_t cur,
   input  angle_t prev,
   output angle_t diff
);

   localparam int DW = ANGLE_W + 1;
   localparam logic signed [DW-1:0] HALF = DW'(ANGLE_HALF);
   localparam logic signed [DW-1:0] FULL = DW'(ANGLE_FULL);

   logic signed [DW-1:0] raw;
   logic signed [DW-1:0] wrapped;

   always_comb begin
      raw     = {cur[ANGLE_W-1], cur} - {prev[ANGLE_W-1], prev};
      wrapped = raw;
      if (raw > HALF) begin
         wrapped = raw - FULL;
      end else if (raw <= -HALF) begin
         wrapped = raw + FULL;
      end
   end

   assign diff = angle_t'(wrapped);

endmodule

// File: rtl/phase_diff_chip_slicer.sv
// Phase-difference integrate-and-dump chip slicer for O-QPSK/MSK.
// Optional chip hysteresis enabled by defining CHIP_HYST_EN.
module phase_diff_chip_slicer
   import cordic_pkg::*;
#(
   parameter int OSR   = 4,
   parameter int ACC_W = 16,
   parameter int HYST  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic signed [15:0] i_angle,
   input  logic               i_valid,
   input  logic               i_clear,
   output logic signed [15:0] o_dphase,
   output logic               o_dphase_valid,
   output logic               o_chip,
   output logic               o_chip_valid
);

`ifdef CHIP_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   localparam int CNT_W = $clog2(OSR);
   localparam int SUM_W = ((ACC_W > ANGLE_W) ? ACC_W : ANGLE_W) + 1;

   localparam logic signed [SUM_W-1:0] SAT_HI =
      SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
   localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;
   localparam logic signed [SUM_W-1:0] HYST_W = SUM_W'(HYST);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   slicer_state_t state;
   angle_t        prev_angle;
   angle_t        d;

   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;

   logic signed [SUM_W-1:0] sum_w;
   logic signed [SUM_W-1:0] sat_w;
   logic signed [SUM_W-1:0] mag;
   logic signed [ACC_W-1:0] s;
   logic                    in_band;
   logic                    chip_next;

   phase_wrap u_wrap (
      .cur  (i_angle),
      .prev (prev_angle),
      .diff (d)
   );

   // Saturating accumulate so large OSR cannot flip the sign by wrapping.
   always_comb begin
      sum_w = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc}
            + {{(SUM_W-ANGLE_W){d[ANGLE_W-1]}}, d};
      sat_w = sum_w;
      if (sum_w > SAT_HI) begin
         sat_w = SAT_HI;
      end else if (sum_w < SAT_LO) begin
         sat_w = SAT_LO;
      end
      s         = ACC_W'(sat_w);
      mag       = sat_w[SUM_W-1] ? -sat_w : sat_w;
      in_band   = mag < HYST_W;
      chip_next = (HYST_ON && in_band) ? o_chip : ~s[ACC_W-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= PRIME;
         prev_angle     <= '0;
         acc            <= '0;
         cnt            <= '0;
         o_dphase       <= '0;
         o_dphase_valid <= 1'b0;
         o_chip         <= 1'b0;
         o_chip_valid   <= 1'b0;
      end else begin
         o_dphase_valid <= 1'b0;
         o_chip_valid   <= 1'b0;
         if (i_clear) begin
            state <= PRIME;
            acc   <= '0;
            cnt   <= '0;
         end else if (i_valid) begin
            prev_angle <= i_angle;
            unique case (state)
               PRIME: begin
                  state <= RUN;
               end
               RUN: begin
                  o_dphase       <= d;
                  o_dphase_valid <= 1'b1;
                  if (cnt == CNT_LAST) begin
                     o_chip       <= chip_next;
                     o_chip_valid <= 1'b1;
                     acc          <= '0;
                     cnt          <= '0;
                  end else begin
                     acc <= s;
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_phase_diff_chip_slicer.sv
// Directed and random scoreboard bench for phase_diff_chip_slicer.
module tb_phase_diff_chip_slicer;
   import cordic_pkg::*;

   localparam int OSR  = 4;
   localparam int HYST = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] i_angle = '0;
   logic               i_valid = 1'b0;
   logic               i_clear = 1'b0;
   logic signed [15:0] o_dphase;
   logic               o_dphase_valid;
   logic               o_chip;
   logic               o_chip_valid;

   int checks = 0;
   int errors = 0;

   int  dq[$];
   bit  cq[$];
   int  m_prev = 0;
   int  m_acc  = 0;
   int  m_cnt  = 0;
   bit  m_run  = 0;
   bit  m_chip = 0;
   int  m_dph  = 0;

   phase_diff_chip_slicer #(
      .OSR   (OSR),
      .ACC_W (16),
      .HYST  (HYST)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .i_angle        (i_angle),
      .i_valid        (i_valid),
      .i_clear        (i_clear),
      .o_dphase       (o_dphase),
      .o_dphase_valid (o_dphase_valid),
      .o_chip         (o_chip),
      .o_chip_valid   (o_chip_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(string tag, logic signed [31:0] obs,
                      logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(bit v, int a, bit c);
      int d;
      int s;
      int mag;
      bit edv;
      bit ecv;
      edv = 0;
      ecv = 0;
      i_valid = v;
      i_angle = 16'(a);
      i_clear = c;
      if (c) begin
         m_run = 0;
         m_acc = 0;
         m_cnt = 0;
      end else if (v) begin
         if (!m_run) begin
            m_run = 1;
         end else begin
            d = a - m_prev;
            if (d > 180) d -= 360;
            else if (d <= -180) d += 360;
            m_dph = d;
            dq.push_back(d);
            edv = 1;
            s = m_acc + d;
            if (m_cnt == OSR - 1) begin
               mag = (s < 0) ? -s : s;
`ifdef CHIP_HYST_EN
               if (mag >= HYST) m_chip = (s >= 0);
`else
               m_chip = (s >= 0);
`endif
               cq.push_back(m_chip);
               ecv = 1;
               m_acc = 0;
               m_cnt = 0;
            end else begin
               m_acc = s;
               m_cnt++;
            end
         end
         m_prev = a;
      end
      @(posedge clock);
      #1;
      i_valid = 0;
      i_clear = 0;
      chk("dphase_valid", o_dphase_valid, edv);
      chk("chip_valid", o_chip_valid, ecv);
      if (o_dphase_valid && dq.size() > 0)
         chk("dphase", o_dphase, dq.pop_front());
      if (o_chip_valid && cq.size() > 0)
         chk("chip", o_chip, cq.pop_front());
      chk("dphase_hold", o_dphase, m_dph);
      chk("chip_hold", o_chip, m_chip);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0);
   endtask

   task automatic feed(int a0, int a1, int a2, int a3, int a4);
      cyc(1, a0, 0);
      cyc(1, a1, 0);
      cyc(1, a2, 0);
      cyc(1, a3, 0);
      cyc(1, a4, 0);
   endtask

   initial begin
      int gaps[5];
      int seq[5];
      gaps = '{0, 1, 7, 1, 0};
      seq  = '{10, 20, 30, 40, 50};

      repeat (3) @(posedge clock);
      #1;
      chk("rst_dphase", o_dphase, 0);
      chk("rst_dphase_valid", o_dphase_valid, 0);
      chk("rst_chip", o_chip, 0);
      chk("rst_chip_valid", o_chip_valid, 0);
      reset = 1'b0;

      // Ramp of +10 per sample.
      feed(10, 20, 30, 40, 50);
      idle(2);

      // Wrap cases: 350->5, 5->350, 350->0, 0->180.
      cyc(0, 0, 1);
      feed(350, 5, 350, 0, 180);
      idle(1);

      // Negative rotation.
      cyc(0, 0, 1);
      feed(100, 80, 60, 40, 20);

      // Small (+4) then large (+40) window after a 0 chip.
      cyc(1, 21, 0);
      cyc(1, 22, 0);
      cyc(1, 23, 0);
      cyc(1, 24, 0);
      cyc(1, 34, 0);
      cyc(1, 44, 0);
      cyc(1, 54, 0);
      cyc(1, 64, 0);
      idle(1);

      // Clear with a coincident sample at cnt = 2.
      cyc(0, 0, 1);
      cyc(1, 0, 0);
      cyc(1, 10, 0);
      cyc(1, 20, 0);
      cyc(1, 99, 1);
      feed(200, 210, 220, 230, 250);
      idle(1);

      // Same ramp with idle gaps between samples.
      cyc(0, 0, 1);
      for (int k = 0; k < 5; k++) begin
         idle(gaps[k]);
         cyc(1, seq[k], 0);
      end
      idle(2);

      // Random angles with random gaps.
      cyc(0, 0, 1);
      for (int k = 0; k < 48; k++) begin
         cyc(1, int'($urandom_range(0, 359)), 0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(2);

      chk("dq_left", dq.size(), 0);
      chk("cq_left", cq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
